// File: rtl/tape_prefetch.sv
// tape_prefetch
// Streams a contiguous byte range out of the SDRAM tape port into a small
// first-word-fall-through FIFO. The tape bit generator drains that FIFO.
// At most one SDRAM read is outstanding at a time.
//
// Ports
//   clk, reset_n        system clock, synchronous active-low reset
//   start, abort        command pulses (abort wins over start)
//   base_addr, length   transfer range, sampled with start
//   tape_addr, tape_rd  SDRAM read address / single-cycle request
//   tape_rd_ack         toggles once per completed read
//   tape_dout           read data, valid when the ack toggle is observed
//   byte_out            FIFO head byte (0 when empty)
//   byte_valid          FIFO not empty
//   byte_ready          consumer pop (pop = byte_valid & byte_ready)
//   busy                transfer in progress
//   done                one-cycle pulse after the final push, or on length 0
//   level               FIFO occupancy
module tape_prefetch #(
  parameter int DEPTH = 8,
  parameter int AW    = 23
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [AW-1:0]            base_addr,
  input  logic [AW-1:0]            length,
  output logic [AW-1:0]            tape_addr,
  output logic                     tape_rd,
  input  logic                     tape_rd_ack,
  input  logic [7:0]               tape_dout,
  output logic [7:0]               byte_out,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic            ack_seen;
  logic            ack_evt;
  logic [AW-1:0]   addr;
  logic [AW-1:0]   remaining;
  logic            last_byte;

  logic [7:0]      fifo [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;

  logic            issue;
  logic            push;
  logic            pop;
  logic            load;
  logic            fin;

  // The ack is a toggle; any difference from the last sampled level is a
  // completed read. ack_seen tracks the line every cycle (also in reset), so
  // a response to a request from before reset is silently absorbed.
  assign ack_evt   = tape_rd_ack ^ ack_seen;
  assign last_byte = (remaining[AW-1:1] == '0);

  assign busy       = (state != S_IDLE);
  assign byte_valid = (level != '0);
  assign byte_out   = byte_valid ? fifo[rd_ptr] : 8'h00;
  assign pop        = byte_valid & byte_ready;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    push      = 1'b0;
    load      = 1'b0;
    fin       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!abort && start) begin
          if (length != '0) begin
            load      = 1'b1;
            state_nxt = S_REQ;
          end else begin
            fin = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else if (level < LW'(DEPTH)) begin
          issue     = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ack_evt) begin
          // An ack coinciding with abort completes the read; nothing is
          // left to drain, so return straight to idle and drop the data.
          if (abort) begin
            state_nxt = S_IDLE;
          end else begin
            push = 1'b1;
            if (last_byte) begin
              fin       = 1'b1;
              state_nxt = S_IDLE;
            end else begin
              state_nxt = S_REQ;
            end
          end
        end else if (abort) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ack_evt) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control registers
  always_ff @(posedge clk) begin
    ack_seen <= tape_rd_ack;
    if (!reset_n) begin
      state     <= S_IDLE;
      tape_rd   <= 1'b0;
      tape_addr <= '0;
      done      <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
    end else begin
      state   <= state_nxt;
      tape_rd <= issue;
      done    <= fin;
      if (issue) tape_addr <= addr;
      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        unique case ({push, pop})
          2'b10:   level <= level + 1'b1;
          2'b01:   level <= level - 1'b1;
          default: level <= level;
        endcase
      end
    end
  end

  // Datapath registers (no reset needed; qualified by control state)
  always_ff @(posedge clk) begin
    if (load) begin
      addr      <= base_addr;
      remaining <= length;
    end else if (push) begin
      addr <= addr + 1'b1;
      if (remaining != '0) remaining <= remaining - 1'b1;
    end
    if (push) fifo[wr_ptr] <= tape_dout;
  end

endmodule

// File: tb/tb_tape_prefetch.sv
module tb_tape_prefetch;

  localparam int DEPTH = 8;
  localparam int AW    = 23;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic            abort;
  logic [AW-1:0]   base_addr;
  logic [AW-1:0]   length;
  logic [AW-1:0]   tape_addr;
  logic            tape_rd;
  logic            tape_rd_ack;
  logic [7:0]      tape_dout;
  logic [7:0]      byte_out;
  logic            byte_valid;
  logic            byte_ready;
  logic            busy;
  logic            done;
  logic [3:0]      level;

  tape_prefetch #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .abort       (abort),
    .base_addr   (base_addr),
    .length      (length),
    .tape_addr   (tape_addr),
    .tape_rd     (tape_rd),
    .tape_rd_ack (tape_rd_ack),
    .tape_dout   (tape_dout),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .busy        (busy),
    .done        (done),
    .level       (level)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0]    exp_q[$];
  logic [AW-1:0] addr_q[$];
  int            rd_cnt   = 0;
  int            done_cnt = 0;
  logic          prev_rd  = 1'b0;

  // Memory model
  logic [7:0]    mem [logic [AW-1:0]];
  int            ack_delay = 0;
  logic          pend      = 1'b0;
  int            pend_cnt  = 0;
  logic [AW-1:0] pend_addr = '0;
  int            flip_req  = 0;
  int            flip_ack  = 0;

  function automatic logic [7:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial tape_rd_ack = 1'b0;
  initial tape_dout   = 8'h00;

  always @(posedge clk) begin
    if (flip_req != flip_ack) begin
      tape_rd_ack <= ~tape_rd_ack;
      flip_ack    <= flip_req;
    end else if (pend) begin
      if (pend_cnt == 0) begin
        tape_rd_ack <= ~tape_rd_ack;
        tape_dout   <= mem_rd(pend_addr);
        pend        <= 1'b0;
      end else begin
        pend_cnt <= pend_cnt - 1;
      end
    end
    if (tape_rd) begin
      if (ack_delay == 0) begin
        tape_rd_ack <= ~tape_rd_ack;
        tape_dout   <= mem_rd(tape_addr);
      end else begin
        pend      <= 1'b1;
        pend_cnt  <= ack_delay - 1;
        pend_addr <= tape_addr;
      end
    end
  end

  // Monitor: byte scoreboard, request address scoreboard, done counting
  always @(negedge clk) begin
    if (reset_n) begin
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) chk("unexpected_byte", 32'(byte_out), 32'hFFFF_FFFF);
        else chk("byte", 32'(byte_out), 32'(exp_q.pop_front()));
      end
      if (tape_rd) begin
        rd_cnt++;
        if (prev_rd) chk("rd_back_to_back", 32'(1), 32'(0));
        if (addr_q.size() == 0) chk("unexpected_rd", 32'(tape_addr), 32'hFFFF_FFFF);
        else chk("rd_addr", 32'(tape_addr), 32'(addr_q.pop_front()));
      end
      if (done) done_cnt++;
    end
    prev_rd = tape_rd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] l);
    @(posedge clk);
    #1;
    base_addr = b;
    length    = l;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0 || addr_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(n < budget), 32'(1));
  endtask

  task automatic chk_reset_values();
    chk("rst_tape_rd",    32'(tape_rd),    32'(0));
    chk("rst_tape_addr",  32'(tape_addr),  32'(0));
    chk("rst_busy",       32'(busy),       32'(0));
    chk("rst_done",       32'(done),       32'(0));
    chk("rst_byte_valid", 32'(byte_valid), 32'(0));
    chk("rst_level",      32'(level),      32'(0));
    chk("rst_byte_out",   32'(byte_out),   32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    base_addr  = '0;
    length     = '0;
    byte_ready = 1'b0;
    repeat (3) tick();
    chk_reset_values();
    reset_n = 1'b1;
    tick();

    // Basic transfer with latency checks
    mem[23'h100] = 8'hA1; mem[23'h101] = 8'hB2;
    mem[23'h102] = 8'hC3; mem[23'h103] = 8'hD4;
    exp_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    addr_q = '{23'h100, 23'h101, 23'h102, 23'h103};
    byte_ready = 1'b1;
    rd_cnt = 0; done_cnt = 0;
    do_start(23'h100, 23'd4);
    chk("c1_busy", 32'(busy), 32'(1));
    chk("c1_tape_rd", 32'(tape_rd), 32'(0));
    tick();
    chk("c2_tape_rd", 32'(tape_rd), 32'(1));
    chk("c2_tape_addr", 32'(tape_addr), 32'h100);
    tick();
    chk("c3_byte_valid", 32'(byte_valid), 32'(0));
    tick();
    chk("c4_byte_valid", 32'(byte_valid), 32'(1));
    chk("c4_byte_out", 32'(byte_out), 32'hA1);
    wait_drain("basic_timeout", 100);
    chk("basic_done_cnt", 32'(done_cnt), 32'(1));
    chk("basic_rd_cnt", 32'(rd_cnt), 32'(4));

    // Backpressure: 20 bytes, consumer stalled
    byte_ready = 1'b0;
    rd_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      exp_q.push_back(8'(i) ^ 8'h3C);
      addr_q.push_back(23'h300 + 23'(i));
    end
    do_start(23'h300, 23'd20);
    repeat (60) tick();
    chk("bp_level_full", 32'(level), 32'(8));
    chk("bp_rd_cnt_stalled", 32'(rd_cnt), 32'(8));
    chk("bp_busy", 32'(busy), 32'(1));
    byte_ready = 1'b1;
    wait_drain("bp_timeout", 200);
    chk("bp_done_cnt", 32'(done_cnt), 32'(1));
    chk("bp_rd_cnt", 32'(rd_cnt), 32'(20));

    // Address wrap-around
    mem[23'h7FFFFE] = 8'h11; mem[23'h7FFFFF] = 8'h22;
    mem[23'h000000] = 8'h33; mem[23'h000001] = 8'h44;
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    addr_q = '{23'h7FFFFE, 23'h7FFFFF, 23'h000000, 23'h000001};
    done_cnt = 0;
    do_start(23'h7FFFFE, 23'd4);
    wait_drain("wrap_timeout", 100);
    chk("wrap_done_cnt", 32'(done_cnt), 32'(1));

    // Zero length
    rd_cnt = 0; done_cnt = 0;
    do_start(23'h400, 23'd0);
    chk("zl_done", 32'(done), 32'(1));
    chk("zl_busy", 32'(busy), 32'(0));
    tick();
    chk("zl_done_clear", 32'(done), 32'(0));
    repeat (4) tick();
    chk("zl_rd_cnt", 32'(rd_cnt), 32'(0));

    // Start while busy is ignored
    rd_cnt = 0; done_cnt = 0;
    exp_q = '{8'h3C, 8'h3D, 8'h3E};
    addr_q = '{23'h500, 23'h501, 23'h502};
    do_start(23'h500, 23'd3);
    tick();
    do_start(23'h600, 23'd5);
    wait_drain("busy_timeout", 100);
    repeat (10) tick();
    chk("busy_rd_cnt", 32'(rd_cnt), 32'(3));
    chk("busy_done_cnt", 32'(done_cnt), 32'(1));

    // Abort in WAIT with a 5-cycle delayed ack
    ack_delay = 5;
    byte_ready = 1'b0;
    rd_cnt = 0; done_cnt = 0;
    addr_q = '{23'h700, 23'h701};
    do_start(23'h700, 23'd4);
    begin
      int n = 0;
      while (level != 4'd1 && n < 50) begin
        tick();
        n++;
      end
      chk("ab_first_byte", 32'(level), 32'(1));
    end
    tick();
    chk("ab_second_rd", 32'(tape_rd), 32'(1));
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab_level_flushed", 32'(level), 32'(0));
    chk("ab_byte_valid", 32'(byte_valid), 32'(0));
    chk("ab_busy_held", 32'(busy), 32'(1));
    byte_ready = 1'b1;
    tick();
    chk("ab_busy_held2", 32'(busy), 32'(1));
    begin
      int n = 0;
      while (busy && n < 20) begin
        tick();
        n++;
      end
      chk("ab_drain_timeout", 32'(n < 20), 32'(1));
    end
    repeat (3) tick();
    chk("ab_no_late_push", 32'(level), 32'(0));
    chk("ab_no_done", 32'(done_cnt), 32'(0));
    ack_delay = 0;
    mem[23'h800] = 8'h5A; mem[23'h801] = 8'hA5;
    exp_q = '{8'h5A, 8'hA5};
    addr_q = '{23'h800, 23'h801};
    do_start(23'h800, 23'd2);
    wait_drain("ab_follow_timeout", 100);
    chk("ab_follow_done", 32'(done_cnt), 32'(1));

    // Reset in WAIT with the ack line high
    if (tape_rd_ack == 1'b0) begin
      flip_req++;
      tick();
      tick();
    end
    chk("rs_ack_high", 32'(tape_rd_ack), 32'(1));
    ack_delay = 5;
    addr_q = '{23'h900};
    do_start(23'h900, 23'd3);
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    tick();
    chk_reset_values();
    reset_n = 1'b1;
    repeat (10) tick();
    chk("rs_idle_level", 32'(level), 32'(0));
    chk("rs_idle_busy", 32'(busy), 32'(0));
    ack_delay = 0;
    done_cnt = 0;
    mem[23'h200] = 8'hC0; mem[23'h201] = 8'hDE;
    exp_q = '{8'hC0, 8'hDE};
    addr_q = '{23'h200, 23'h201};
    do_start(23'h200, 23'd2);
    wait_drain("rs_follow_timeout", 100);
    repeat (5) tick();
    chk("rs_follow_done", 32'(done_cnt), 32'(1));
    chk("rs_follow_level", 32'(level), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
